// File: rtl/fifo_pkg.sv
// Shared defaults, width helpers and operation encoding for the parametrised
// show-ahead FIFO (fifo_sync_param and its storage sub-module).
package fifo_pkg;

  localparam int FIFO_DATA_SIZE_DEF = 32;
  localparam int FIFO_DEPTH_DEF     = 8;

  // Ceiling log2; callers guarantee value >= 2.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int fifo_ptr_w(input int depth);
    return clog2(depth);
  endfunction

  // Count needs one extra bit to represent the completely full state.
  function automatic int fifo_cnt_w(input int depth);
    return clog2(depth) + 1;
  endfunction

  typedef logic [fifo_ptr_w(FIFO_DEPTH_DEF)-1:0] fifo_ptr_def_t;
  typedef logic [fifo_cnt_w(FIFO_DEPTH_DEF)-1:0] fifo_cnt_def_t;

  // Encoded as {push, pop} so it can be built directly from the two strobes.
  typedef enum logic [1:0] {
    FIFO_OP_IDLE = 2'b00,
    FIFO_OP_POP  = 2'b01,
    FIFO_OP_PUSH = 2'b10,
    FIFO_OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_sync_param_if.sv
// rts/rtr handshake bundle between a producer, the FIFO and a consumer.
// The FIFO uses the slave modport; the driving environment uses master.
interface fifo_sync_param_if
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = FIFO_DATA_SIZE_DEF
);

  logic [DATA_SIZE-1:0] fifo_inp_data;
  logic                 fifo_inp_rts;
  logic                 fifo_inp_rtr;
  logic [DATA_SIZE-1:0] fifo_out_data;
  logic                 fifo_out_rts;
  logic                 fifo_out_rtr;

  modport slave (
    input  fifo_inp_data,
    input  fifo_inp_rts,
    output fifo_inp_rtr,
    output fifo_out_data,
    output fifo_out_rts,
    input  fifo_out_rtr
  );

  modport master (
    output fifo_inp_data,
    output fifo_inp_rts,
    input  fifo_inp_rtr,
    input  fifo_out_data,
    input  fifo_out_rts,
    output fifo_out_rtr
  );

endinterface

// File: rtl/fifo_mem.sv
// One-write / one-asynchronous-read register array backing the FIFO.
// Storage is deliberately left unreset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = FIFO_DATA_SIZE_DEF,
  parameter int DEPTH     = FIFO_DEPTH_DEF
)(
  input  logic                         clk,
  input  logic                         i_we,
  input  logic [fifo_ptr_w(DEPTH)-1:0] i_waddr,
  input  logic [DATA_SIZE-1:0]         i_wdata,
  input  logic [fifo_ptr_w(DEPTH)-1:0] i_raddr,
  output logic [DATA_SIZE-1:0]         o_rdata
);

  logic [DATA_SIZE-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Show-ahead: the head word is visible without a read strobe.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock show-ahead FIFO with occupancy count, almost flags and flush.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = FIFO_DATA_SIZE_DEF,
  parameter int DEPTH     = FIFO_DEPTH_DEF,
  parameter int AF_LEVEL  = DEPTH - 2,
  parameter int AE_LEVEL  = 2
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fifo_clear,
  fifo_sync_param_if.slave             bus,
  output logic [fifo_cnt_w(DEPTH)-1:0] fifo_count,
  output logic                         fifo_almost_full,
  output logic                         fifo_almost_empty
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                         fifo_ovf,
  output logic                         fifo_udf
`endif
);

  localparam int PTR_W = fifo_ptr_w(DEPTH);
  localparam int CNT_W = fifo_cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [31:0]      AF_U     = 32'(AF_LEVEL);
  localparam logic [31:0]      AE_U     = 32'(AE_LEVEL);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_almost_full;
  logic             r_almost_empty;

  logic             w_inp_rtr;
  logic             w_out_rts;
  logic             w_push;
  logic             w_pop;
  fifo_op_e         w_op;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_af_nxt;
  logic             w_ae_nxt;

  // Handshake readiness depends on registered count only, never on rts.
  assign w_inp_rtr = (r_count != FULL_CNT);
  assign w_out_rts = (r_count != '0);
  assign w_push    = bus.fifo_inp_rts & w_inp_rtr;
  assign w_pop     = bus.fifo_out_rtr & w_out_rts;
  assign w_op      = fifo_op_e'({w_push, w_pop});

  always_comb begin
    w_cnt_nxt = r_count;
    if (fifo_clear) begin
      w_cnt_nxt = '0;
    end else begin
      unique case (w_op)
        FIFO_OP_PUSH: w_cnt_nxt = r_count + CNT_W'(1);
        FIFO_OP_POP:  w_cnt_nxt = r_count - CNT_W'(1);
        default:      w_cnt_nxt = r_count;
      endcase
    end
  end

  // Flags look at the next-state count so they move together with fifo_count.
  assign w_af_nxt = (32'(w_cnt_nxt) >= AF_U);
  assign w_ae_nxt = (32'(w_cnt_nxt) <= AE_U);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else if (fifo_clear) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count        <= w_cnt_nxt;
      r_almost_full  <= w_af_nxt;
      r_almost_empty <= w_ae_nxt;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic r_ovf;
  logic r_udf;

  // Sticky: only reset or flush clears them, and flush wins over a new event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (fifo_clear) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (bus.fifo_inp_rts && !w_inp_rtr) begin
        r_ovf <= 1'b1;
      end
      if (bus.fifo_out_rtr && !w_out_rts) begin
        r_udf <= 1'b1;
      end
    end
  end

  assign fifo_ovf = r_ovf;
  assign fifo_udf = r_udf;
`endif

  fifo_mem #(
    .DATA_SIZE (DATA_SIZE),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push & ~fifo_clear),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.fifo_inp_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (bus.fifo_out_data)
  );

  assign bus.fifo_inp_rtr = w_inp_rtr;
  assign bus.fifo_out_rts = w_out_rts;
  assign fifo_count        = r_count;
  assign fifo_almost_full  = r_almost_full;
  assign fifo_almost_empty = r_almost_empty;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: directed steps plus random traffic checked
// against a queue-based model of the FIFO behaviour.
module tb_fifo_sync_param;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic       clk;
  logic       rst;
  logic       fifo_clear;
  logic [3:0] fifo_count;
  logic       fifo_almost_full;
  logic       fifo_almost_empty;
`ifdef FIFO_ERR_FLAGS_EN
  logic       fifo_ovf;
  logic       fifo_udf;
`endif

  fifo_sync_param_if #(.DATA_SIZE(DW)) bus ();

  fifo_sync_param #(
    .DATA_SIZE (DW),
    .DEPTH     (DEPTH),
    .AF_LEVEL  (AF),
    .AE_LEVEL  (AE)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .fifo_clear        (fifo_clear),
    .bus               (bus),
    .fifo_count        (fifo_count),
    .fifo_almost_full  (fifo_almost_full),
    .fifo_almost_empty (fifo_almost_empty)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .fifo_ovf          (fifo_ovf),
    .fifo_udf          (fifo_udf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] q[$];
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int sz;
    sz = q.size();
    check({tag, ".count"}, 64'(fifo_count), 64'(sz));
    check({tag, ".out_rts"}, 64'(bus.fifo_out_rts), 64'(sz != 0));
    check({tag, ".inp_rtr"}, 64'(bus.fifo_inp_rtr), 64'(sz != DEPTH));
    check({tag, ".af"}, 64'(fifo_almost_full), 64'(sz >= AF));
    check({tag, ".ae"}, 64'(fifo_almost_empty), 64'(sz <= AE));
    if (sz != 0) check({tag, ".head"}, 64'(bus.fifo_out_data), 64'(q[0]));
`ifdef FIFO_ERR_FLAGS_EN
    check({tag, ".ovf"}, 64'(fifo_ovf), 64'(m_ovf));
    check({tag, ".udf"}, 64'(fifo_udf), 64'(m_udf));
`endif
  endtask

  // Called just after a rising edge; applies inputs, waits one edge, checks.
  task automatic step(input string tag, input bit rts, input logic [DW-1:0] d,
                      input bit rtr, input bit clr);
    bit do_push;
    bit do_pop;
    bus.fifo_inp_rts  = rts;
    bus.fifo_inp_data = d;
    bus.fifo_out_rtr  = rtr;
    fifo_clear        = clr;
    do_push = rts && (q.size() != DEPTH);
    do_pop  = rtr && (q.size() != 0);
    if (rts && q.size() == DEPTH) m_ovf = 1'b1;
    if (rtr && q.size() == 0)     m_udf = 1'b1;
    if (do_pop) check({tag, ".pop_data"}, 64'(bus.fifo_out_data), 64'(q[0]));
    @(posedge clk);
    #1;
    if (clr) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(d);
    end
    bus.fifo_inp_rts = 1'b0;
    bus.fifo_out_rtr = 1'b0;
    fifo_clear       = 1'b0;
    check_state(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst               = 1'b0;
    fifo_clear        = 1'b0;
    bus.fifo_inp_rts  = 1'b0;
    bus.fifo_inp_data = '0;
    bus.fifo_out_rtr  = 1'b0;
    @(posedge clk);
    #1;
    check_state("reset");
    rst = 1'b1;

    step("push1", 1'b1, 32'd1, 1'b0, 1'b0);
    check("push1.data_direct", 64'(bus.fifo_out_data), 64'd1);
    step("push2_pop", 1'b1, 32'd2, 1'b1, 1'b0);
    check("push2_pop.head_direct", 64'(bus.fifo_out_data), 64'd2);

    for (int k = 1; k <= 13; k++) step("fill", 1'b1, DW'(10 * k), 1'b0, 1'b0);
    check("full.rtr_direct", 64'(bus.fifo_inp_rtr), 64'd0);
    check("full.count_direct", 64'(fifo_count), 64'd8);

    for (int k = 0; k < 8; k++) step("drain", 1'b0, '0, 1'b1, 1'b0);
    step("underflow", 1'b0, '0, 1'b1, 1'b0);
    check("empty.rts_direct", 64'(bus.fifo_out_rts), 64'd0);

    for (int i = 0; i < 3; i++) step("wrap_pre", 1'b1, DW'(i), 1'b0, 1'b0);
    for (int i = 3; i < 20; i++) begin
      check("wrap.head_order", 64'(bus.fifo_out_data), 64'(i - 3));
      step("wrap", 1'b1, DW'(i), 1'b1, 1'b0);
    end
    for (int i = 17; i < 20; i++) begin
      check("wrap_post.head_order", 64'(bus.fifo_out_data), 64'(i));
      step("wrap_post", 1'b0, '0, 1'b1, 1'b0);
    end

    for (int i = 0; i < 300; i++) begin
      bit rts_r;
      bit rtr_r;
      bit clr_r;
      if (i < 150) begin
        rts_r = ($urandom_range(0, 3) != 0);
        rtr_r = ($urandom_range(0, 3) == 0);
      end else begin
        rts_r = ($urandom_range(0, 3) == 0);
        rtr_r = ($urandom_range(0, 3) != 0);
      end
      clr_r = ($urandom_range(0, 31) == 0);
      step("rand", rts_r, DW'($urandom), rtr_r, clr_r);
    end

    step("clr_prep", 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step("clr_fill", 1'b1, DW'(100 + i), 1'b0, 1'b0);
    check("clr_fill.count_direct", 64'(fifo_count), 64'd5);
    step("clear", 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    check("clear.count_direct", 64'(fifo_count), 64'd0);
    check("clear.rts_direct", 64'(bus.fifo_out_rts), 64'd0);
    check("clear.rtr_direct", 64'(bus.fifo_inp_rtr), 64'd1);

    for (int i = 0; i < 7; i++) step("pre_rst", 1'b1, DW'($urandom), 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    check_state("async_rst");
    check("async_rst.count_direct", 64'(fifo_count), 64'd0);
    @(posedge clk);
    #1;
    check_state("rst_hold");
    rst = 1'b1;
    for (int i = 0; i < 20; i++)
      step("post_rst", 1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
